// File: rtl/fpu_div_pkg.sv
// Shared definitions for the FDIV mantissa divider: FSM state encoding and default width.
package fpu_div_pkg;

    localparam int unsigned DIV_DEF_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_div_nr_if.sv
// Start/busy/valid handshake bundle for seq_div_nr.
//   master: FPU control side (drives start + operands, observes status/results)
//   slave : divider side
interface seq_div_nr_if
    import fpu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_DEF_WIDTH
) ();

    logic             i_start;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_busy, o_valid, o_quotient, o_remainder, o_div_zero
    );

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_busy, o_valid, o_quotient, o_remainder, o_div_zero
    );

endinterface

// File: rtl/addsub_nb.sv
// N-bit ripple add/subtract cell: sum = a + (b ^ {N{sub}}) + sub.
//   a, b : operands
//   sub  : 1 = subtract (inverts b and supplies the carry-in)
//   sum  : N-bit result, cout : carry out
module addsub_nb #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned NW = N + 1;

    logic [N:0] full;

    always_comb begin
        full = NW'(a) + NW'(b ^ {N{sub}}) + NW'(sub);
    end

    assign sum  = full[N-1:0];
    assign cout = full[N];

endmodule

// File: rtl/seq_div_nr.sv
// Multi-cycle unsigned non-restoring divider, one quotient bit per cycle.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of the start/busy/valid handshake (operands in, results out)
// Latency from accepted start to o_valid is WIDTH+2 cycles, or 1 cycle for a zero divisor.
module seq_div_nr
    import fpu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_DEF_WIDTH
) (
    input logic        i_clk,
    input logic        i_rst_n,
    seq_div_nr_if.slave bus
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, valid_q;

    logic [RW-1:0]    r_shift;
    logic [RW-1:0]    as_a, as_b, as_sum;
    logic             as_sub;
    logic             unused_cout;

    // Partial remainder shifted left with the next dividend bit from the top of Q
    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign as_b    = {1'b0, d_q};

    // Single shared add/sub; the carry-out is meaningless in modulo-2^RW arithmetic
    addsub_nb #(.N(RW)) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (unused_cout)
    );

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        as_a    = r_shift;
        as_sub  = ~r_q[WIDTH];

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    d_d   = bus.i_divisor;
                    q_d   = bus.i_dividend;
                    r_d   = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (bus.i_divisor == '0) begin
                        dz_d    = 1'b1;
                        quo_d   = '1;
                        rem_d   = bus.i_dividend;
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                // Subtract when the old remainder is non-negative, add otherwise
                r_d = as_sum;
                q_d = {q_q[WIDTH-2:0], ~as_sum[WIDTH]};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                // Restore a negative final remainder by adding D back
                as_a   = r_q;
                as_sub = 1'b0;
                if (r_q[WIDTH]) begin
                    r_d = as_sum;
                end
                quo_d   = q_q;
                rem_d   = r_d[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            busy_q  <= (state_d != IDLE);
            valid_q <= (state_d == DONE);
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_quotient  = quo_q;
    assign bus.o_remainder = rem_q;
    assign bus.o_div_zero  = dz_q;

endmodule
